// File: rtl/ddr3_pkg.sv
// Shared types and helpers for the multi-port MIG arbiter.
package ddr3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_BURST,
        ST_RD_CMD,
        ST_RD_DRAIN
    } state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr3_rr_arbiter.sv
// Round-robin arbiter: first asserted request after the last grant.
module ddr3_rr_arbiter
    import ddr3_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(i_last) + k;
            if (j >= N) j = j - N;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ddr3_mport_arbit.sv
// N-write / M-read burst arbiter in front of the MIG native app port.
module ddr3_mport_arbit
    import ddr3_pkg::*;
#(
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int BURST_LEN  = 64,
    parameter int ADDR_STEP  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_calib_complete,
    input  logic [NUM_WR-1:0]              wr_req,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr_begin,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr_end,
    input  logic [NUM_WR-1:0]              wr_addr_clr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_WR-1:0]              wr_data_pop,
    input  logic [NUM_RD-1:0]              rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_begin,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_end,
    input  logic [NUM_RD-1:0]              rd_addr_clr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_RD-1:0]              rd_data_vld,
    output logic                           app_en,
    output logic [2:0]                     app_cmd,
    output logic [ADDR_WIDTH-1:0]          app_addr,
    input  logic                           app_rdy,
    output logic                           app_wdf_wren,
    output logic                           app_wdf_end,
    output logic [DATA_WIDTH-1:0]          app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]        app_wdf_mask,
    input  logic                           app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]          app_rd_data,
    input  logic                           app_rd_data_valid
);

    localparam int NREQ = NUM_WR + NUM_RD;
    localparam int IW   = clog2(NREQ);
    localparam int WW   = (NUM_WR > 1) ? clog2(NUM_WR) : 1;
    localparam int RW   = (NUM_RD > 1) ? clog2(NUM_RD) : 1;
    localparam int CW   = clog2(BURST_LEN) + 1;
    localparam int AW   = ADDR_WIDTH;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] FULL      = CW'(BURST_LEN);
    localparam logic [AW:0]   STEP      = (AW+1)'(ADDR_STEP);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_sel;
    logic [IW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   r_rcnt;
    logic [CW-1:0]   w_rcnt_nxt;
    logic [RW-1:0]   r_rd_ch;
    logic            r_loaded;
    logic            w_grant;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_gnt_rd;
    logic            w_wr_fire;
    logic            w_rd_fire;
    logic            w_fire;
    logic            w_busy;
    logic [WW-1:0]   w_wsel;
    logic [AW-1:0]   w_ptr  [NREQ];
    logic [DATA_WIDTH-1:0] w_wdat [NUM_WR];

    ddr3_rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .i_req  ({rd_req, wr_req}),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_gnt_rd  = |w_gnt[NREQ-1:NUM_WR];
    assign w_wr_fire = (r_state == ST_WR_BURST) && app_rdy && app_wdf_rdy;
    assign w_rd_fire = (r_state == ST_RD_CMD) && app_rdy;
    assign w_fire    = w_wr_fire || w_rd_fire;
    assign w_busy    = (r_state == ST_WR_BURST) || (r_state == ST_RD_CMD)
                    || (r_state == ST_RD_DRAIN);
    assign w_wsel    = r_sel[WW-1:0];
    assign w_rcnt_nxt = r_rcnt + CW'(app_rd_data_valid);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (init_calib_complete) w_state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (!init_calib_complete) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_any) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_gnt_rd ? ST_RD_CMD : ST_WR_BURST;
                end
            end
            ST_WR_BURST: begin
                if (w_wr_fire) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_BEAT) w_state_nxt = ST_ARB;
                end
            end
            ST_RD_CMD: begin
                if (w_rd_fire) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_BEAT) w_state_nxt = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                if (w_rcnt_nxt == FULL) w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_last   <= IW'(NREQ - 1);
            r_cnt    <= '0;
            r_rcnt   <= '0;
            r_rd_ch  <= '0;
            r_loaded <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_loaded <= 1'b1;
            if (w_grant) begin
                r_sel  <= w_idx;
                r_last <= w_idx;
                r_rcnt <= '0;
                if (w_gnt_rd) r_rd_ch <= RW'(int'(w_idx) - NUM_WR);
            end else if (r_state == ST_RD_CMD || r_state == ST_RD_DRAIN) begin
                r_rcnt <= w_rcnt_nxt;
            end
        end
    end

    // Returns always go to the read channel latched at its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data     <= '0;
            rd_data_vld <= '0;
        end else begin
            rd_data_vld <= '0;
            if (app_rd_data_valid) begin
                rd_data     <= app_rd_data;
                rd_data_vld <= NUM_RD'(1) << r_rd_ch;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_ch
            logic [AW-1:0] w_beg;
            logic [AW-1:0] w_end;
            logic          w_clr;
            logic          w_active;
            logic [AW:0]   w_sum;
            logic [AW-1:0] w_nxt;
            logic [AW-1:0] r_ptr;
            logic          r_pend;

            if (g < NUM_WR) begin : g_wr
                assign w_beg = wr_addr_begin[g*AW +: AW];
                assign w_end = wr_addr_end[g*AW +: AW];
                assign w_clr = wr_addr_clr[g];
                assign w_wdat[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_rd
                assign w_beg = rd_addr_begin[(g-NUM_WR)*AW +: AW];
                assign w_end = rd_addr_end[(g-NUM_WR)*AW +: AW];
                assign w_clr = rd_addr_clr[g-NUM_WR];
            end

            assign w_active = w_busy && (r_sel == IW'(g));
            assign w_sum    = {1'b0, r_ptr} + STEP;
            assign w_nxt    = (w_sum > {1'b0, w_end}) ? w_beg : w_sum[AW-1:0];
            assign w_ptr[g] = r_ptr;

            // A clear during the channel's own burst waits for the burst end.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr  <= '0;
                    r_pend <= 1'b0;
                end else if (!r_loaded) begin
                    r_ptr  <= w_beg;
                end else if (w_active) begin
                    if (w_fire) r_ptr <= w_nxt;
                    if (w_clr)  r_pend <= 1'b1;
                end else if (w_clr || r_pend) begin
                    r_ptr  <= w_beg;
                    r_pend <= 1'b0;
                end
            end
        end
    endgenerate

    assign app_en       = w_fire;
    assign app_cmd      = (r_state == ST_RD_CMD) ? CMD_RD : CMD_WR;
    assign app_addr     = w_busy ? w_ptr[r_sel] : '0;
    assign app_wdf_wren = w_wr_fire;
    assign app_wdf_end  = w_wr_fire;
    assign app_wdf_data = (r_state == ST_WR_BURST) ? w_wdat[w_wsel] : '0;
    assign app_wdf_mask = '0;
    assign wr_data_pop  = w_wr_fire ? (NUM_WR'(1) << w_wsel) : '0;

endmodule

// File: tb/tb_ddr3_mport_arbit.sv
// Directed bench for ddr3_mport_arbit: 2 write + 2 read ports, 4-beat bursts.
module tb_ddr3_mport_arbit;

    localparam int NW = 2;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 28;
    localparam int BL = 4;
    localparam int AS = 8;

    logic             clk;
    logic             rst_n;
    logic             init_calib_complete;
    logic [NW-1:0]    wr_req;
    logic [NW*AW-1:0] wr_addr_begin;
    logic [NW*AW-1:0] wr_addr_end;
    logic [NW-1:0]    wr_addr_clr;
    logic [NW*DW-1:0] wr_data;
    logic [NW-1:0]    wr_data_pop;
    logic [NR-1:0]    rd_req;
    logic [NR*AW-1:0] rd_addr_begin;
    logic [NR*AW-1:0] rd_addr_end;
    logic [NR-1:0]    rd_addr_clr;
    logic [DW-1:0]    rd_data;
    logic [NR-1:0]    rd_data_vld;
    logic             app_en;
    logic [2:0]       app_cmd;
    logic [AW-1:0]    app_addr;
    logic             app_rdy;
    logic             app_wdf_wren;
    logic             app_wdf_end;
    logic [DW-1:0]    app_wdf_data;
    logic [DW/8-1:0]  app_wdf_mask;
    logic             app_wdf_rdy;
    logic [DW-1:0]    app_rd_data;
    logic             app_rd_data_valid;

    logic [DW-1:0]    wd0;
    logic [DW-1:0]    wd1;
    int               ncmp;
    int               nerr;

    assign wr_data = {wd1, wd0};

    ddr3_mport_arbit #(
        .NUM_WR     (NW),
        .NUM_RD     (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_LEN  (BL),
        .ADDR_STEP  (AS)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .wr_req              (wr_req),
        .wr_addr_begin       (wr_addr_begin),
        .wr_addr_end         (wr_addr_end),
        .wr_addr_clr         (wr_addr_clr),
        .wr_data             (wr_data),
        .wr_data_pop         (wr_data_pop),
        .rd_req              (rd_req),
        .rd_addr_begin       (rd_addr_begin),
        .rd_addr_end         (rd_addr_end),
        .rd_addr_clr         (rd_addr_clr),
        .rd_data             (rd_data),
        .rd_data_vld         (rd_data_vld),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".en"}, 64'(app_en), 64'(0));
        chk({tag, ".pop"}, 64'(wr_data_pop), 64'(0));
    endtask

    task automatic chk_wr(input string tag, input int ch,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, ".en"}, 64'(app_en), 64'(1));
        chk({tag, ".cmd"}, 64'(app_cmd), 64'(3'b000));
        chk({tag, ".addr"}, 64'(app_addr), 64'(a));
        chk({tag, ".pop"}, 64'(wr_data_pop), 64'(1 << ch));
        chk({tag, ".data"}, 64'(app_wdf_data), 64'(d));
        chk({tag, ".wren_end"}, 64'({app_wdf_wren, app_wdf_end}), 64'(2'b11));
    endtask

    task automatic chk_rd(input string tag, input logic [AW-1:0] a);
        chk({tag, ".en"}, 64'(app_en), 64'(1));
        chk({tag, ".cmd"}, 64'(app_cmd), 64'(3'b001));
        chk({tag, ".addr"}, 64'(app_addr), 64'(a));
        chk({tag, ".pop"}, 64'(wr_data_pop), 64'(0));
        chk({tag, ".wren"}, 64'(app_wdf_wren), 64'(0));
    endtask

    function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p,
                                             input logic [AW-1:0] b,
                                             input logic [AW-1:0] e);
        logic [AW:0] s;
        s = {1'b0, p} + (AW+1)'(AS);
        return (s > {1'b0, e}) ? b : s[AW-1:0];
    endfunction

    // One burst: waits for the grant (bounded), checks the idle gap, then 4 beats.
    task automatic run_burst(input string tag, input int ch, input bit rd,
                             input logic [AW-1:0] b, input logic [AW-1:0] e,
                             input logic [AW-1:0] a0, input int gap);
        int idle;
        bit got;
        logic [AW-1:0] a;
        idle = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (app_en) begin
                got = 1'b1;
                break;
            end
            idle++;
            step();
            app_rd_data_valid = 1'b0;
        end
        chk({tag, ".granted"}, 64'(got), 64'(1));
        if (!got) return;
        chk({tag, ".gap"}, 64'(idle), 64'(gap));
        a = a0;
        for (int k = 0; k < BL; k++) begin
            if (k > 0) @(negedge clk);
            if (rd) chk_rd(tag, a);
            else chk_wr(tag, ch, a, (ch == 0) ? wd0 : wd1);
            step();
            if (rd) app_rd_data_valid = 1'b1;
            else if (ch == 0) wd0++;
            else wd1++;
            a = nxt_ptr(a, b, e);
        end
    endtask

    initial begin
        logic [AW-1:0] wrap_a [4];
        wrap_a = '{28'h0, 28'h8, 28'h10, 28'h0};
        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        wr_req = '0;
        rd_req = '0;
        wr_addr_clr = '0;
        rd_addr_clr = '0;
        wr_addr_begin = {28'h0, 28'h100};
        wr_addr_end   = {28'h10, 28'hFFFF};
        rd_addr_begin = {28'h400, 28'h300};
        rd_addr_end   = {28'h4FF, 28'h3FF};
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data = '0;
        app_rd_data_valid = 1'b0;
        wd0 = 32'hA000_0000;
        wd1 = 32'hB000_0000;

        @(negedge clk);
        chk("rst.en", 64'(app_en), 64'(0));
        chk("rst.pop", 64'(wr_data_pop), 64'(0));
        chk("rst.vld", 64'(rd_data_vld), 64'(0));
        chk("rst.rdata", 64'(rd_data), 64'(0));
        chk("rst.addr", 64'(app_addr), 64'(0));
        chk("rst.mask", 64'(app_wdf_mask), 64'(0));
        step();
        rst_n = 1'b1;
        wr_req = 2'b01;

        repeat (5) begin
            @(negedge clk);
            chk_idle("cal");
            step();
        end
        init_calib_complete = 1'b1;
        @(negedge clk);
        chk_idle("lat.idle");
        step();
        @(negedge clk);
        chk_idle("lat.arb");
        step();

        for (int k = 0; k < BL; k++) begin
            @(negedge clk);
            chk_wr("w0", 0, 28'h100 + 28'(8 * k), wd0);
            step();
            wd0++;
            if (k == 0) wr_req = 2'b00;
        end
        repeat (2) begin
            @(negedge clk);
            chk_idle("w0.after");
            step();
        end

        wr_req = 2'b10;
        @(negedge clk);
        chk_idle("bp.arb");
        step();
        @(negedge clk);
        chk_wr("bp", 1, wrap_a[0], wd1);
        step();
        wd1++;
        app_wdf_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("bp.stall");
            chk("bp.hold", 64'(app_wdf_data), 64'(wd1));
            step();
        end
        app_wdf_rdy = 1'b1;
        for (int k = 1; k < BL; k++) begin
            @(negedge clk);
            chk_wr("bp", 1, wrap_a[k], wd1);
            step();
            wd1++;
            if (k == BL - 1) wr_req = 2'b00;
        end

        rd_req = 2'b10;
        @(negedge clk);
        chk_idle("rd1.arb");
        step();
        for (int k = 0; k < BL; k++) begin
            @(negedge clk);
            chk_rd("rd1", 28'h400 + 28'(8 * k));
            step();
        end
        rd_req = 2'b00;
        wr_req = 2'b01;
        repeat (10) begin
            @(negedge clk);
            chk_idle("drain.wait");
            chk("drain.vld", 64'(rd_data_vld), 64'(0));
            step();
        end
        for (int k = 0; k < BL; k++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = 32'hD0 + 32'(k);
            @(negedge clk);
            chk_idle("drain.ret");
            if (k > 0) begin
                chk("drain.vld", 64'(rd_data_vld), 64'(2'b10));
                chk("drain.data", 64'(rd_data), 64'(32'hD0 + 32'(k - 1)));
            end
            step();
        end
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        chk_idle("drain.arb");
        chk("drain.vld4", 64'(rd_data_vld), 64'(2'b10));
        chk("drain.data4", 64'(rd_data), 64'(32'hD3));
        step();
        @(negedge clk);
        chk_wr("post", 0, 28'h120, wd0);
        chk("post.vld", 64'(rd_data_vld), 64'(0));
        step();
        wd0++;

        rst_n = 1'b0;
        wr_req = 2'b11;
        rd_req = 2'b11;
        @(negedge clk);
        chk("mrst.en", 64'(app_en), 64'(0));
        chk("mrst.pop", 64'(wr_data_pop), 64'(0));
        chk("mrst.wren", 64'(app_wdf_wren), 64'(0));
        chk("mrst.addr", 64'(app_addr), 64'(0));
        chk("mrst.data", 64'(app_wdf_data), 64'(0));
        chk("mrst.cmd", 64'(app_cmd), 64'(0));
        step();
        rst_n = 1'b1;

        run_burst("rr.wr0", 0, 1'b0, 28'h100, 28'hFFFF, 28'h100, 2);
        run_burst("rr.wr1", 1, 1'b0, 28'h0, 28'h10, 28'h0, 1);
        run_burst("rr.rd0", 2, 1'b1, 28'h300, 28'h3FF, 28'h300, 1);
        run_burst("rr.rd1", 3, 1'b1, 28'h400, 28'h4FF, 28'h400, 2);
        run_burst("rr.wr0b", 0, 1'b0, 28'h100, 28'hFFFF, 28'h120, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
